mdio_slave_ctrl: RTL and testbench
==================================

Name: mdio_slave_ctrl

Overview:
- Clause-22 MDIO management slave for the ADC capture chip.
- Oversamples MDC and MDIO received from the pad cells on the core clock.
- Decodes read and write frames addressed to this device and bridges them to the internal register bank through a single-cycle strobe interface.
- Drives the MDIO pad data and output-enable during the read turnaround and data phases.

Parameters:
- PHY_ADDR, 5'd1, device address that frames must match.
- PRE_LEN, 32, minimum count of consecutive 1 bits required before a start-of-frame is accepted.
- SYNC_STG, 2, synchronizer depth on mdc and mdio_in (minimum 2).

Ports:
- clk  in  1  core clock; must be at least 8x the MDC frequency.
- rst  in  1  synchronous, active-high reset.
- mdc  in  1  MDC from the pad receive path, asynchronous.
- mdio_in  in  1  MDIO from the pad receive path, asynchronous.
- mdio_out  out  1  data to the MDIO pad driver.
- mdio_oen  out  1  pad output enable, active low (0 = drive).
- reg_addr  out  5  register address, valid while reg_rd or reg_wr is high.
- reg_wdata  out  16  write data, valid while reg_wr is high.
- reg_wr  out  1  one-clk write strobe.
- reg_rd  out  1  one-clk read strobe.
- reg_rdata  in  16  read data; bank returns it exactly 1 clk after reg_rd.
- busy  out  1  high from ST detection until the frame ends.
- frame_err  out  1  one-clk pulse on a protocol error.

Behaviour:
- Reset values: mdio_out=0, mdio_oen=1, reg_wr=0, reg_rd=0, frame_err=0, busy=0, reg_addr=0, reg_wdata=0. State is HUNT, preamble count 0.
- mdc and mdio_in each pass through SYNC_STG flops.
- rise = sync mdc transitions 0->1; fall = sync mdc transitions 1->0.
- All bit sampling occurs on rise; all mdio_out and mdio_oen changes occur on fall.
- HUNT state:
  - Each sampled 1 increments pre_cnt, saturating at PRE_LEN.
  - A sampled 0 with pre_cnt < PRE_LEN clears pre_cnt.
  - A sampled 0 with pre_cnt == PRE_LEN goes to ST and sets busy.
- ST state: the next bit must be 1, else frame_err and return to HUNT with pre_cnt=0.
- OP state: 2 bits; 10 = read, 01 = write. Any other value gives frame_err and HUNT.
- PHYAD state: 5 bits, MSB first; match = (PHYAD == PHY_ADDR).
- REGAD state: 5 bits, MSB first, latched into reg_addr.
  - On the rise sampling REGAD[0], if read and match, assert reg_rd for 1 clk.
  - The following clk, capture reg_rdata into the 16-bit shift register.
- TA state, read with match:
  - TA1: mdio_oen stays 1.
  - On the fall after the TA1 rise, mdio_oen=0 and mdio_out=0 (TA2).
  - On each of the next 16 falls, drive shreg[15] and shift left, so data goes out MSB first.
  - On the fall after the rise that samples data bit 0, mdio_oen=1 and mdio_out=0, busy=0, go to HUNT.
- TA state, write with match:
  - The 2 TA bits must be sampled as 1,0; otherwise frame_err, and the frame finishes without a write.
  - The 16 data bits are shifted into reg_wdata.
  - In the clk after the rise of data bit 0, reg_wr=1 for 1 clk, then busy=0 and HUNT.
- Address mismatch:
  - mdio_oen stays 1 and no strobes are issued.
  - The remaining 18 bit times (TA + data) are counted, then HUNT.
  - No frame_err.
- pre_cnt is cleared on every frame exit, so each frame needs a fresh preamble of PRE_LEN ones.
- Preamble-looking bits inside TA or data are ignored; the frame is bit-counted and cannot be aborted.
- rst mid-frame: immediate reset values and HUNT on the next clk. mdio_oen=1 ensures the pad is released.
- A static MDC causes no state change.
- reg_rd and reg_wr are never asserted in the same clk.

Test Plan:
- Write path: 32 ones, ST=01, OP=01, PHYAD=1, REGAD=5'h03, TA=10, data 16'h1234 -> single reg_wr with reg_addr=3, reg_wdata=16'h1234; frame_err=0; mdio_oen=1 throughout.
- Read path: 32 ones, OP=10, REGAD=5'h07, bank returns 16'hA5C3 -> single reg_rd. mdio_oen is 1 during TA1 and falls at the following MDC fall. The next 17 bits driven are 0,1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. mdio_oen returns to 1 after the last bit.
- Address mismatch: read frame to PHYAD=5'h02 -> no reg_rd, mdio_oen stays 1, no frame_err. An immediately following valid write frame is accepted.
- Short preamble: 31 ones then 01 10 ... -> no strobes, busy stays 0. Repeating the frame with 32 ones succeeds.
- Protocol errors:
  - ST=00 after a full preamble -> frame_err pulse, busy drops, HUNT.
  - Write with TA=11 -> frame_err and no reg_wr.
- Reset mid-read: assert rst on the 8th data bit of a read -> mdio_oen=1 and mdio_out=0 on the next clk, busy=0. A subsequent full read returns correct data.

Source files
------------

// File: rtl/mdio_slave_ctrl.sv
// Clause-22 MDIO management slave: oversampled MDC/MDIO front end, frame decoder,
// and a single-cycle strobe bridge to the register bank.
module mdio_slave_ctrl #(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter int         PRE_LEN  = 32,
  parameter int         SYNC_STG = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        busy,
  output logic        frame_err
);

  localparam int            PW      = $clog2(PRE_LEN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRE_LEN);

  localparam logic [2:0] HUNT  = 3'd0;
  localparam logic [2:0] ST    = 3'd1;
  localparam logic [2:0] OP    = 3'd2;
  localparam logic [2:0] PHYAD = 3'd3;
  localparam logic [2:0] REGAD = 3'd4;
  localparam logic [2:0] TA    = 3'd5;
  localparam logic [2:0] DATA  = 3'd6;
  localparam logic [2:0] FIN   = 3'd7;

  logic [SYNC_STG-1:0] mdc_sync_r;
  logic [SYNC_STG-1:0] mdio_sync_r;
  logic                mdc_prev_r;
  logic                mdc_s;
  logic                mdio_s;
  logic                rise_s;
  logic                fall_s;

  logic [2:0]    state_r;
  logic [PW-1:0] pre_cnt_r;
  logic [3:0]    bit_cnt_r;
  logic          op_hi_r;
  logic          is_rd_r;
  logic          match_r;
  logic [3:0]    phy_r;
  logic          ta0_r;
  logic          ta_err_r;
  logic          cap_r;
  logic [15:0]   shreg_r;
  logic          rd_match_s;
  logic          wr_match_s;

  assign mdc_s      = mdc_sync_r[SYNC_STG-1];
  assign mdio_s     = mdio_sync_r[SYNC_STG-1];
  assign rise_s     = mdc_s & ~mdc_prev_r;
  assign fall_s     = ~mdc_s & mdc_prev_r;
  assign rd_match_s = is_rd_r & match_r;
  assign wr_match_s = ~is_rd_r & match_r;

  // Pad synchronizers; left out of reset so they keep tracking MDC and no false edge appears on release
  always_ff @(posedge clk) begin
    mdc_sync_r  <= {mdc_sync_r[SYNC_STG-2:0], mdc};
    mdio_sync_r <= {mdio_sync_r[SYNC_STG-2:0], mdio_in};
    mdc_prev_r  <= mdc_s;
  end

  // Frame decoder, bank strobes and pad drive
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= HUNT;
      pre_cnt_r <= '0;
      bit_cnt_r <= 4'd0;
      op_hi_r   <= 1'b0;
      is_rd_r   <= 1'b0;
      match_r   <= 1'b0;
      phy_r     <= 4'd0;
      ta0_r     <= 1'b0;
      ta_err_r  <= 1'b0;
      cap_r     <= 1'b0;
      shreg_r   <= 16'd0;
      mdio_out  <= 1'b0;
      mdio_oen  <= 1'b1;
      reg_addr  <= 5'd0;
      reg_wdata <= 16'd0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      frame_err <= 1'b0;
      // Bank answers one clk after reg_rd, so capture on the delayed strobe
      cap_r     <= reg_rd;
      if (cap_r) begin
        shreg_r <= reg_rdata;
      end

      if (rise_s) begin
        case (state_r)
          HUNT: begin
            if (mdio_s) begin
              if (pre_cnt_r != PRE_MAX) begin
                pre_cnt_r <= pre_cnt_r + PW'(1);
              end
            end else if (pre_cnt_r == PRE_MAX) begin
              state_r <= ST;
              busy    <= 1'b1;
            end else begin
              pre_cnt_r <= '0;
            end
          end
          ST: begin
            if (mdio_s) begin
              state_r   <= OP;
              bit_cnt_r <= 4'd0;
            end else begin
              frame_err <= 1'b1;
              busy      <= 1'b0;
              pre_cnt_r <= '0;
              state_r   <= HUNT;
            end
          end
          OP: begin
            if (bit_cnt_r == 4'd0) begin
              op_hi_r   <= mdio_s;
              bit_cnt_r <= 4'd1;
            end else if (op_hi_r != mdio_s) begin
              is_rd_r   <= op_hi_r;
              state_r   <= PHYAD;
              bit_cnt_r <= 4'd0;
            end else begin
              frame_err <= 1'b1;
              busy      <= 1'b0;
              pre_cnt_r <= '0;
              state_r   <= HUNT;
            end
          end
          PHYAD: begin
            phy_r <= {phy_r[2:0], mdio_s};
            if (bit_cnt_r == 4'd4) begin
              match_r   <= ({phy_r, mdio_s} == PHY_ADDR);
              state_r   <= REGAD;
              bit_cnt_r <= 4'd0;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
          REGAD: begin
            reg_addr <= {reg_addr[3:0], mdio_s};
            if (bit_cnt_r == 4'd4) begin
              reg_rd    <= rd_match_s;
              ta_err_r  <= 1'b0;
              state_r   <= TA;
              bit_cnt_r <= 4'd0;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
          TA: begin
            if (bit_cnt_r == 4'd0) begin
              ta0_r     <= mdio_s;
              bit_cnt_r <= 4'd1;
            end else begin
              if (wr_match_s && !(ta0_r && !mdio_s)) begin
                frame_err <= 1'b1;
                ta_err_r  <= 1'b1;
              end
              state_r   <= DATA;
              bit_cnt_r <= 4'd0;
            end
          end
          DATA: begin
            if (wr_match_s) begin
              reg_wdata <= {reg_wdata[14:0], mdio_s};
            end
            if (bit_cnt_r == 4'd15) begin
              reg_wr  <= wr_match_s & ~ta_err_r;
              state_r <= FIN;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
          default: begin
          end
        endcase
      end

      // Read data leaves on MDC falls: TA2 zero, then the shift register MSB first
      if (fall_s && rd_match_s) begin
        if (state_r == TA && bit_cnt_r == 4'd1) begin
          mdio_oen <= 1'b0;
          mdio_out <= 1'b0;
        end else if (state_r == DATA) begin
          mdio_out <= shreg_r[15];
          shreg_r  <= {shreg_r[14:0], 1'b0};
        end
      end

      if (state_r == FIN) begin
        if (!rd_match_s || fall_s) begin
          mdio_oen  <= 1'b1;
          mdio_out  <= 1'b0;
          busy      <= 1'b0;
          pre_cnt_r <= '0;
          state_r   <= HUNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_slave_ctrl.sv
// Bench for mdio_slave_ctrl: directed and randomized Clause-22 frames checked against
// a field-level model of the expected bank strobes and pad drive.
module tb_mdio_slave_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oen;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdata = 16'd0;
  logic        busy;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;

  int wr_cyc   = 0;
  int rd_cyc   = 0;
  int err_cyc  = 0;
  int busy_cyc = 0;
  int oen_cyc  = 0;
  int both_cyc = 0;
  logic [4:0]  last_waddr = 5'd0;
  logic [4:0]  last_raddr = 5'd0;
  logic [15:0] last_wdata = 16'd0;

  logic [15:0] bank [32];
  logic [1:0]  obs  [33];

  always #5 clk = ~clk;

  mdio_slave_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .mdc       (mdc),
    .mdio_in   (mdio_in),
    .mdio_out  (mdio_out),
    .mdio_oen  (mdio_oen),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // Register bank: valid data exactly one clk after reg_rd, noise otherwise
  always @(posedge clk) begin
    if (reg_rd) reg_rdata <= bank[reg_addr];
    else        reg_rdata <= 16'($urandom);
  end

  always @(negedge clk) begin
    if (reg_wr) begin
      wr_cyc     <= wr_cyc + 1;
      last_waddr <= reg_addr;
      last_wdata <= reg_wdata;
    end
    if (reg_rd) begin
      rd_cyc     <= rd_cyc + 1;
      last_raddr <= reg_addr;
    end
    if (reg_rd && reg_wr) both_cyc <= both_cyc + 1;
    if (frame_err)        err_cyc  <= err_cyc + 1;
    if (busy)             busy_cyc <= busy_cyc + 1;
    if (!mdio_oen)        oen_cyc  <= oen_cyc + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One MDC period: low half with data set up, pad sampled just before the rise, then high half
  task automatic bit_t(input logic d, output logic [1:0] o);
    @(negedge clk);
    mdc     = 1'b0;
    mdio_in = d;
    repeat (8) @(negedge clk);
    o   = {mdio_oen, mdio_out};
    mdc = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_frame(input int npre, input logic [1:0] st, input logic [1:0] op,
                           input logic [4:0] phy, input logic [4:0] regad,
                           input logic [1:0] ta, input logic [15:0] data, input int abort_at);
    logic [31:0] fr;
    logic [1:0]  o;
    logic [15:0] bw;
    logic [1:0]  exp_bit;
    int s_wr, s_rd, s_err, s_busy, s_oen, s_both;
    bit pre_ok, st_ok, op_ok, match, in_frame, exp_err, exp_wr, exp_rd;
    s_wr = wr_cyc; s_rd = rd_cyc; s_err = err_cyc;
    s_busy = busy_cyc; s_oen = oen_cyc; s_both = both_cyc;
    fr = {st, op, phy, regad, ta, data};
    bit_t(1'b0, o);
    repeat (npre) bit_t(1'b1, o);
    for (int i = 0; i < 32; i++) begin
      if (i == abort_at) begin
        @(negedge clk);
        mdc     = 1'b0;
        mdio_in = fr[31-i];
        repeat (8) @(negedge clk);
        chk("abort_pre_oen", 32'(mdio_oen), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_oen", 32'(mdio_oen), 32'd1);
        chk("abort_out", 32'(mdio_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        mdc = 1'b1;
        repeat (8) @(negedge clk);
        return;
      end
      bit_t(fr[31-i], obs[i]);
    end
    bit_t(1'b1, obs[32]);
    repeat (4) @(negedge clk);

    pre_ok   = (npre >= 32);
    st_ok    = (st == 2'b01);
    op_ok    = (op == 2'b10) || (op == 2'b01);
    match    = (phy == 5'd1);
    in_frame = pre_ok && st_ok && op_ok;
    exp_err  = pre_ok && (!st_ok || !op_ok || (op == 2'b01 && match && ta != 2'b10));
    exp_wr   = in_frame && op == 2'b01 && match && ta == 2'b10;
    exp_rd   = in_frame && op == 2'b10 && match;

    chk("wr_strobes", 32'(wr_cyc - s_wr), 32'(exp_wr));
    chk("rd_strobes", 32'(rd_cyc - s_rd), 32'(exp_rd));
    chk("err_pulses", 32'(err_cyc - s_err), 32'(exp_err));
    chk("rd_wr_overlap", 32'(both_cyc - s_both), 32'd0);
    chk("busy_seen", 32'((busy_cyc - s_busy) > 0), 32'(pre_ok));
    chk("busy_end", 32'(busy), 32'd0);
    if (exp_wr) begin
      chk("wr_addr", 32'(last_waddr), 32'(regad));
      chk("wr_data", 32'(last_wdata), 32'(data));
    end
    if (exp_rd) begin
      chk("rd_addr", 32'(last_raddr), 32'(regad));
    end else begin
      chk("oen_never_low", 32'(oen_cyc - s_oen), 32'd0);
    end
    bw = bank[regad];
    for (int i = 14; i < 33; i++) begin
      exp_bit = 2'b10;
      if (exp_rd && i == 15) exp_bit = 2'b00;
      if (exp_rd && i >= 16 && i <= 31) exp_bit = {1'b0, bw[31-i]};
      chk($sformatf("pad_bit%0d", i), 32'(obs[i]), 32'(exp_bit));
    end
  endtask

  initial begin
    logic [1:0]  rop;
    logic [4:0]  rphy;
    rst     = 1'b1;
    mdc     = 1'b0;
    mdio_in = 1'b1;
    for (int i = 0; i < 32; i++) bank[i] = 16'($urandom);
    bank[7] = 16'hA5C3;
    repeat (6) @(negedge clk);
    chk("rst_out", 32'(mdio_out), 32'd0);
    chk("rst_oen", 32'(mdio_oen), 32'd1);
    chk("rst_strobes", 32'({reg_wr, reg_rd, frame_err, busy}), 32'd0);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_wdata", 32'(reg_wdata), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    run_frame(32, 2'b01, 2'b01, 5'd1, 5'h03, 2'b10, 16'h1234, -1);
    run_frame(32, 2'b01, 2'b10, 5'd1, 5'h07, 2'b11, 16'($urandom), -1);
    run_frame(32, 2'b01, 2'b10, 5'd2, 5'($urandom), 2'b11, 16'($urandom), -1);
    run_frame(32, 2'b01, 2'b01, 5'd1, 5'($urandom), 2'b10, 16'($urandom), -1);
    run_frame(31, 2'b01, 2'b10, 5'd1, 5'h07, 2'b11, 16'hFFFF, -1);
    run_frame(32, 2'b01, 2'b10, 5'd1, 5'h07, 2'b11, 16'hFFFF, -1);
    run_frame(32, 2'b00, 2'b10, 5'd1, 5'h07, 2'b11, 16'h0000, -1);
    run_frame(32, 2'b01, 2'b01, 5'd1, 5'h05, 2'b11, 16'hBEEF, -1);
    run_frame(32, 2'b01, 2'b10, 5'd1, 5'h07, 2'b11, 16'hFFFF, 23);
    repeat (4) @(negedge clk);
    run_frame(32, 2'b01, 2'b10, 5'd1, 5'h07, 2'b11, 16'($urandom), -1);

    for (int n = 0; n < 6; n++) begin
      rop  = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
      rphy = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd1;
      run_frame(32 + $urandom_range(0, 6), 2'b01, rop, rphy, 5'($urandom),
                2'b10, 16'($urandom), -1);
    end
    run_frame(32, 2'b01, 2'b10, 5'd1, 5'h03, 2'b11, 16'($urandom), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
